// File: rtl/gray_codec_pipe.sv
// Pipelined Gray<->binary codec with valid/ready flow control.
// Optional Gray step checker enabled by GRAY_CODEC_STEP_CHECK_EN.
module gray_codec_pipe #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_mode,
  output logic [N-1:0] out_data,
  output logic         step_err
);

  localparam int P = (N + STAGES - 1) / STAGES;

  function automatic int slot_lo(input int k);
    int v;
    v = N - (k + 1) * P;
    if (k == STAGES - 1) v = 0;
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int slot_hi(input int k);
    return N - 1 - k * P;
  endfunction

  // Resolve Gray bits hi..lo MSB-first, seeded by bits already in r
  function automatic logic [N-1:0] resolve(
    input logic [N-1:0] g,
    input logic [N-1:0] r,
    input int           lo,
    input int           hi
  );
    logic [N-1:0] x;
    logic [N-1:0] sh;
    x = r;
    for (int i = N - 1; i >= 0; i--) begin
      sh = x >> 1;
      if (i >= lo && i <= hi) x[i] = g[i] ^ sh[i];
    end
    return x;
  endfunction

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] mode_q, mode_d;
  logic [N-1:0]      word_q [STAGES];
  logic [N-1:0]      word_d [STAGES];
  logic [N-1:0]      res_q  [STAGES];
  logic [N-1:0]      res_d  [STAGES];
  logic              adv;

  assign out_valid = vld_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];
  assign out_data  = res_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    word_d = word_q;
    res_d  = res_q;
    if (adv) begin
      vld_d[0]  = in_valid;
      mode_d[0] = in_mode;
      word_d[0] = in_data;
      if (in_mode)
        res_d[0] = resolve(in_data, '0, slot_lo(0), slot_hi(0));
      else
        res_d[0] = in_data ^ (in_data >> 1);
      for (int k = 1; k < STAGES; k++) begin
        vld_d[k]  = vld_q[k-1];
        mode_d[k] = mode_q[k-1];
        word_d[k] = word_q[k-1];
        if (mode_q[k-1])
          res_d[k] = resolve(word_q[k-1], res_q[k-1],
                             slot_lo(k), slot_hi(k));
        else
          res_d[k] = res_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      mode_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        word_q[k] <= '0;
        res_q[k]  <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      for (int k = 0; k < STAGES; k++) begin
        word_q[k] <= word_d[k];
        res_q[k]  <= res_d[k];
      end
    end
  end

`ifdef GRAY_CODEC_STEP_CHECK_EN
  logic [N-1:0] ref_q, ref_d;
  logic         ref_set_q, ref_set_d;
  logic         err_q, err_d;

  always_comb begin
    ref_d     = ref_q;
    ref_set_d = ref_set_q;
    err_d     = 1'b0;
    if (in_valid && adv && in_mode) begin
      if (ref_set_q && ($countones(in_data ^ ref_q) != 1))
        err_d = 1'b1;
      ref_d     = in_data;
      ref_set_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q     <= '0;
      ref_set_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ref_q     <= ref_d;
      ref_set_q <= ref_set_d;
      err_q     <= err_d;
    end
  end

  assign step_err = err_q;
`else
  assign step_err = 1'b0;
`endif

endmodule
